// File: rtl/instr_mem_responder.sv
// Instruction fetch responder: single-outstanding request/response handshake
// in front of a preloadable word memory, with fixed wait states and fault reporting.
module instr_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [31:0]                    req_addr,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [31:0]                    rsp_instr,
  output logic [1:0]                     rsp_fault,
  input  logic                           load_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
  input  logic [31:0]                    load_data,
  output logic [31:0]                    fetch_count
);

  localparam int          AW          = $clog2(DEPTH_WORDS);
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam logic [29:0] DEPTH_LIMIT = 30'(DEPTH_WORDS);
  localparam logic [2:0]  WAIT_LOAD   = 3'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t       state_reg, state_next;
  logic [2:0]   wait_cnt_reg, wait_cnt_next;
  logic [AW-1:0] addr_reg;
  logic [31:0]  rsp_instr_reg;
  logic [1:0]   rsp_fault_reg;
  logic [31:0]  fetch_count_reg;

  logic [31:0]  mem [DEPTH_WORDS];

  logic [1:0]   req_fault;
  logic [1:0]   resp_fault;
  logic [AW-1:0] rd_idx;
  logic         accept;
  logic         rsp_done;
  logic         enter_resp;

  // Misalignment takes priority over range.
  always_comb begin
    req_fault = 2'b00;
    if (req_addr[1:0] != 2'b00) begin
      req_fault = 2'b01;
    end else if (req_addr[31:2] >= DEPTH_LIMIT) begin
      req_fault = 2'b10;
    end
  end

  assign accept   = (state_reg == S_IDLE) && req_valid;
  assign rsp_done = (state_reg == S_RESP) && rsp_ready;

  // Only a request accepted straight from IDLE can fault; WAIT is reached by good requests only.
  assign resp_fault = (state_reg == S_IDLE) ? req_fault : 2'b00;
  assign rd_idx     = (state_reg == S_IDLE) ? req_addr[AW+1:2] : addr_reg;

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    enter_resp    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (req_valid) begin
          if ((req_fault != 2'b00) || (WAIT_STATES == 0)) begin
            state_next = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_next    = S_WAIT;
            wait_cnt_next = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        wait_cnt_next = wait_cnt_reg - 3'd1;
        if (wait_cnt_reg == 3'd1) begin
          state_next = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= S_IDLE;
      wait_cnt_reg    <= 3'd0;
      addr_reg        <= '0;
      rsp_instr_reg   <= 32'd0;
      rsp_fault_reg   <= 2'b00;
      fetch_count_reg <= 32'd0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (accept) begin
        addr_reg <= req_addr[AW+1:2];
      end
      // Registered memory read on the edge entering RESP; a same-edge preload yields the old word.
      if (enter_resp) begin
        rsp_fault_reg <= resp_fault;
        rsp_instr_reg <= (resp_fault == 2'b00) ? mem[rd_idx] : NOP_INSTR;
      end
      if (rsp_done) begin
        fetch_count_reg <= fetch_count_reg + 32'd1;
      end
    end
  end

  // Memory is deliberately outside the reset domain so preloaded code survives reset.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  assign req_ready   = (state_reg == S_IDLE);
  assign rsp_valid   = (state_reg == S_RESP);
  assign rsp_instr   = rsp_instr_reg;
  assign rsp_fault   = rsp_fault_reg;
  assign fetch_count = fetch_count_reg;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench: two responders (1 and 3 wait states) share stimulus; each is
// checked against hand-computed latency, data, fault and count values.
module tb_instr_mem_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        rsp_ready;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [31:0] load_data;

  logic        r1_req_ready, r1_rsp_valid;
  logic [31:0] r1_rsp_instr, r1_fetch_count;
  logic [1:0]  r1_rsp_fault;
  logic        r3_req_ready, r3_rsp_valid;
  logic [31:0] r3_rsp_instr, r3_fetch_count;
  logic [1:0]  r3_rsp_fault;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_cnt  = 32'd0;

  instr_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(r1_req_ready), .req_addr(req_addr),
    .rsp_valid(r1_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_instr(r1_rsp_instr), .rsp_fault(r1_rsp_fault),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .fetch_count(r1_fetch_count)
  );

  instr_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(r3_req_ready), .req_addr(req_addr),
    .rsp_valid(r3_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_instr(r3_rsp_instr), .rsp_fault(r3_rsp_fault),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .fetch_count(r3_fetch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    load_en   = 1'b1;
    load_addr = idx;
    load_data = val;
    tick();
    load_en   = 1'b0;
  endtask

  // Issues one request with rsp_ready held high; optionally preloads during cycle N+load_cyc.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] ei1, input logic [31:0] ei3,
                          input logic [1:0] ef, input int load_cyc,
                          input logic [7:0] load_idx, input logic [31:0] load_val);
    int          lat1 = 0;
    int          lat3 = 0;
    logic [31:0] i1 = 32'd0;
    logic [31:0] i3 = 32'd0;
    logic [1:0]  f1 = 2'b00;
    logic [1:0]  f3 = 2'b00;
    req_valid = 1'b1;
    req_addr  = addr;
    rsp_ready = 1'b1;
    settle();
    check("req_ready_ws1", 32'(r1_req_ready), 32'd1);
    for (int c = 1; c <= 10; c++) begin
      tick();
      req_valid = 1'b0;
      load_en   = (c == load_cyc);
      load_addr = load_idx;
      load_data = load_val;
      settle();
      if (r1_rsp_valid && lat1 == 0) begin
        lat1 = c; i1 = r1_rsp_instr; f1 = r1_rsp_fault;
      end
      if (r3_rsp_valid && lat3 == 0) begin
        lat3 = c; i3 = r3_rsp_instr; f3 = r3_rsp_fault;
      end
    end
    tick();
    load_en = 1'b0;
    exp_cnt = exp_cnt + 32'd1;
    $display("txn addr=%h | ws1 instr=%h fault=%0d lat=%0d | ws3 instr=%h fault=%0d lat=%0d | count=%0d",
             addr, i1, f1, lat1, i3, f3, lat3, r1_fetch_count);
    check("latency_ws1", 32'(lat1), (ef != 2'b00) ? 32'd1 : 32'd2);
    check("latency_ws3", 32'(lat3), (ef != 2'b00) ? 32'd1 : 32'd4);
    check("instr_ws1", i1, ei1);
    check("instr_ws3", i3, ei3);
    check("fault_ws1", 32'(f1), 32'(ef));
    check("fault_ws3", 32'(f3), 32'(ef));
    check("count_ws1", r1_fetch_count, exp_cnt);
    check("count_ws3", r3_fetch_count, exp_cnt);
  endtask

  logic [31:0] t_addr  [7];
  logic [31:0] t_instr [7];
  logic [1:0]  t_fault [7];
  logic        saw_rsp;

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_addr = 32'd0; rsp_ready = 1'b0;
    load_en = 1'b0; load_addr = 8'd0; load_data = 32'd0;

    t_addr  = '{32'h0000_000C, 32'h0000_0006, 32'h0000_0400, 32'h0000_03FC,
                32'h0000_0403, 32'h8000_0000, 32'h0000_0008};
    t_instr = '{32'h0050_0093, NOP, NOP, 32'hA5A5_A5A5, NOP, NOP, 32'h1111_1111};
    t_fault = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00};

    repeat (3) tick();
    settle();
    check("rst_req_ready", 32'(r1_req_ready), 32'd1);
    check("rst_rsp_valid", 32'(r1_rsp_valid), 32'd0);
    check("rst_rsp_instr", r1_rsp_instr, 32'd0);
    check("rst_rsp_fault", 32'(r1_rsp_fault), 32'd0);
    check("rst_count", r1_fetch_count, 32'd0);
    tick();
    reset = 1'b1;

    preload(8'd3, 32'h0050_0093);
    preload(8'd2, 32'h1111_1111);
    preload(8'd255, 32'hA5A5_A5A5);

    for (int i = 0; i < 7; i++) begin
      do_fetch(t_addr[i], t_instr[i], t_instr[i], t_fault[i], 0, 8'd0, 32'd0);
    end

    // Response stall with a second request presented while busy.
    req_valid = 1'b1; req_addr = 32'h0000_000C; rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    settle();
    check("stall_wait_valid", 32'(r1_rsp_valid), 32'd0);
    tick();
    settle();
    check("stall_first_valid", 32'(r1_rsp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      req_valid = 1'b1;
      req_addr  = 32'h0000_0008;
      settle();
      check("stall_valid", 32'(r1_rsp_valid), 32'd1);
      check("stall_instr", r1_rsp_instr, 32'h0050_0093);
      check("stall_fault", 32'(r1_rsp_fault), 32'd0);
      check("stall_req_ready", 32'(r1_req_ready), 32'd0);
    end
    tick();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    settle();
    check("stall_ws3_valid", 32'(r3_rsp_valid), 32'd1);
    check("stall_ws3_instr", r3_rsp_instr, 32'h0050_0093);
    tick();
    settle();
    exp_cnt = exp_cnt + 32'd1;
    check("stall_idle_ready", 32'(r1_req_ready), 32'd1);
    check("stall_idle_valid", 32'(r1_rsp_valid), 32'd0);
    check("stall_ws3_idle", 32'(r3_req_ready), 32'd1);
    check("stall_count_ws1", r1_fetch_count, exp_cnt);
    check("stall_count_ws3", r3_fetch_count, exp_cnt);
    tick();

    // Preload during WAIT is visible; preload on the RESP-entry edge is not.
    do_fetch(32'h0000_0008, 32'h1111_1111, 32'hDEAD_BEEF, 2'b00, 2, 8'd2, 32'hDEAD_BEEF);
    do_fetch(32'h0000_0008, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b00, 3, 8'd2, 32'hCAFE_F00D);
    do_fetch(32'h0000_0008, 32'hCAFE_F00D, 32'hCAFE_F00D, 2'b00, 0, 8'd0, 32'd0);

    // Asynchronous reset in the middle of WAIT.
    req_valid = 1'b1; req_addr = 32'h0000_000C; rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    #1;
    check("pre_rst_ws3_busy", 32'(r3_req_ready), 32'd0);
    #1;
    reset = 1'b0;
    #1;
    check("async_rst_valid_ws1", 32'(r1_rsp_valid), 32'd0);
    check("async_rst_ready_ws1", 32'(r1_req_ready), 32'd1);
    check("async_rst_ready_ws3", 32'(r3_req_ready), 32'd1);
    check("async_rst_count_ws1", r1_fetch_count, 32'd0);
    check("async_rst_count_ws3", r3_fetch_count, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    saw_rsp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      settle();
      if (r1_rsp_valid || r3_rsp_valid) saw_rsp = 1'b1;
      tick();
    end
    check("no_rsp_after_reset", 32'(saw_rsp), 32'd0);
    exp_cnt = 32'd0;
    do_fetch(32'h0000_000C, 32'h0050_0093, 32'h0050_0093, 2'b00, 0, 8'd0, 32'd0);

    // Counter wrap via backdoor deposit.
    dut1.fetch_count_reg = 32'hFFFF_FFFF;
    dut3.fetch_count_reg = 32'hFFFF_FFFF;
    settle();
    check("deposit_count", r1_fetch_count, 32'hFFFF_FFFF);
    tick();
    exp_cnt = 32'hFFFF_FFFF;
    do_fetch(32'h0000_0006, NOP, NOP, 2'b01, 0, 8'd0, 32'd0);
    check("wrap_count", r1_fetch_count, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_mem_responder.md
INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit instruction words stored (power of two, 16..4096).
REQ-002 Parameter WAIT_STATES, default 1, extra cycles between request accept and response (0..7).
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port req_valid  input  1  fetch request present.
REQ-006 Port req_ready  output  1  responder can accept a request this cycle.
REQ-007 Port req_addr  input  32  byte address of instruction (the PC value).
REQ-008 Port rsp_valid  output  1  response present.
REQ-009 Port rsp_ready  input  1  consumer accepts response this cycle.
REQ-010 Port rsp_instr  output  32  fetched instruction word.
REQ-011 Port rsp_fault  output  2  00 ok, 01 misaligned, 10 out of range, 11 unused.
REQ-012 Port load_en  input  1  write enable of the preload port.
REQ-013 Port load_addr  input  log2(DEPTH_WORDS)  word index for preload.
REQ-014 Port load_data  input  32  word written by preload.
REQ-015 Port fetch_count  output  32  number of completed response handshakes.

Function
REQ-016 Request handshake SHALL occur on a cycle with req_valid=1 and req_ready=1; response handshake on rsp_valid=1 and rsp_ready=1.
REQ-017 FSM states SHALL be IDLE, WAIT, RESP; one request outstanding at most.
REQ-018 req_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in RESP.
REQ-019 IDLE + request handshake: capture req_addr; faulting request -> RESP next cycle; else WAIT_STATES=0 -> RESP next cycle; else -> WAIT with wait counter loaded to WAIT_STATES.
REQ-020 WAIT: counter decrements each cycle; transition to RESP on the cycle the counter reaches 1.
REQ-021 Latency: request accepted in cycle N -> rsp_valid first high in cycle N+1+WAIT_STATES for non-faulting requests, N+1 for faulting requests.
REQ-022 Fault rule: req_addr[1:0]!=00 -> 01 (misaligned, priority); else req_addr[31:2] >= DEPTH_WORDS -> 10; else 00.
REQ-023 Faulting response SHALL drive rsp_instr = 32'h00000013 (NOP); memory not read.
REQ-024 Non-faulting response: rsp_instr = memory[req_addr[31:2]] sampled on the clock edge entering RESP.
REQ-025 RESP: rsp_instr and rsp_fault held stable until response handshake; handshake -> IDLE next cycle, so next request accept is no earlier than the cycle after the handshake.
REQ-026 fetch_count SHALL increment by 1 on every response handshake, including faulting ones; wraps 32'hFFFFFFFF -> 0.
REQ-027 Preload write on any cycle with load_en=1, in any state; a write and a read to the same word on the same edge returns the old word.
REQ-028 Writes completed before the edge entering RESP SHALL be visible in that response.
REQ-029 req_valid while not in IDLE SHALL be ignored (no capture, no state effect).

Reset
REQ-030 reset=0 SHALL force, immediately and regardless of clk: state IDLE, req_ready=1, rsp_valid=0, rsp_instr=0, rsp_fault=00, wait counter=0, fetch_count=0.
REQ-031 Reset mid-request (WAIT or RESP) SHALL drop the request with no response produced.
REQ-032 Memory contents SHALL NOT be cleared by reset; preloaded words persist across reset.
REQ-033 Deassertion of reset is synchronous to clk; first accept possible on the first rising edge with reset=1.

Verification
REQ-034 WAIT_STATES=1; preload word 3 = 32'h00500093; request 32'h0000000C at cycle N, rsp_ready=1 -> rsp_valid at N+2, rsp_instr=32'h00500093, rsp_fault=00, fetch_count=1.
REQ-035 Request 32'h00000006 -> rsp_valid at N+1, rsp_fault=01, rsp_instr=32'h00000013; request 32'h00000400 (DEPTH_WORDS=256) -> rsp_fault=10.
REQ-036 rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_instr, rsp_fault unchanged, req_ready=0, second req_valid ignored; rsp_ready=1 -> IDLE next cycle.
REQ-037 WAIT_STATES=3; load word 2 = 32'hDEADBEEF during WAIT of request 32'h00000008 -> response returns 32'hDEADBEEF; same-edge load as RESP entry -> old word.
REQ-038 Assert reset=0 mid-WAIT -> rsp_valid=0, req_ready=1, fetch_count=0 immediately; after release, request word 3 -> preloaded value still returned.
REQ-039 Force fetch_count to 32'hFFFFFFFF via 2^32 handshakes or backdoor; one handshake -> fetch_count=0.
